// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous memory (one-cycle read
//               latency) between two masters. Master 0 is the mips core and
//               master 1 is the program loader / debug port.
//               Grants are issued combinationally, in the same cycle as the
//               request. Ties use round-robin priority. A master may use a
//               bounded lock to hold ownership for back-to-back bursts.
//               Read data is steered back to the master that issued the read.
// Ports       : clk, rstb                - clock, synchronous active-low reset
//               mN_req/we/lock           - master N request, write, lock
//               mN_addr/wdata            - master N address, write data
//               mN_gnt                   - master N access issued this cycle
//               mN_rvalid/rdata          - master N read return
//               mem_addr/wr_data/wr_ena  - memory command
//               mem_rd_data              - memory read data (1 cycle later)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_wr_ena,
   input  logic [DATA_W-1:0] mem_rd_data
);

   localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);
   localparam logic [3:0] c_hold_sat = 4'hF;

   // State records who owned the previous cycle's grant.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_last_owner;
   logic [3:0] r_hold_cnt;
   logic       r_lock_q;
   logic       r_m0_rvalid;
   logic       r_m1_rvalid;

   logic       w_gnt0;
   logic       w_gnt1;
   logic       w_hold_ok;
   logic       w_last_nxt;
   logic       w_lock_nxt;
   logic [3:0] w_hold_nxt;
   logic [3:0] w_hold_inc;
   logic       w_m0_rvalid;
   logic       w_m1_rvalid;

   // Previous owner may keep the port only if it locked at its last grant
   // and has not yet used up its hold allowance against a competitor.
   assign w_hold_ok  = r_lock_q && (r_hold_cnt < c_max_hold);
   assign w_hold_inc = (r_hold_cnt == c_hold_sat) ? r_hold_cnt : r_hold_cnt + 4'd1;

   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_state_nxt = IDLE;
      w_last_nxt  = r_last_owner;
      w_lock_nxt  = 1'b0;
      w_hold_nxt  = 4'd0;

      if (rstb) begin
         if (m0_req && m1_req) begin
            if ((r_state == OWN0) && w_hold_ok) begin
               w_gnt0 = 1'b1;
            end else if ((r_state == OWN1) && w_hold_ok) begin
               w_gnt1 = 1'b1;
            end else if (r_last_owner) begin
               w_gnt0 = 1'b1;
            end else begin
               w_gnt1 = 1'b1;
            end
         end else begin
            w_gnt0 = m0_req;
            w_gnt1 = m1_req;
         end
      end

      // Hold count only advances when a repeat grant actually blocked the
      // other master; a sole requester never consumes its allowance.
      if (w_gnt0) begin
         w_state_nxt = OWN0;
         w_last_nxt  = 1'b0;
         w_lock_nxt  = m0_lock;
         if ((r_state == OWN0) && m1_req) begin
            w_hold_nxt = w_hold_inc;
         end
      end else if (w_gnt1) begin
         w_state_nxt = OWN1;
         w_last_nxt  = 1'b1;
         w_lock_nxt  = m1_lock;
         if ((r_state == OWN1) && m0_req) begin
            w_hold_nxt = w_hold_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_state      <= IDLE;
         r_last_owner <= 1'b1;
         r_hold_cnt   <= 4'd0;
         r_lock_q     <= 1'b0;
         r_m0_rvalid  <= 1'b0;
         r_m1_rvalid  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_owner <= w_last_nxt;
         r_hold_cnt   <= w_hold_nxt;
         r_lock_q     <= w_lock_nxt;
         r_m0_rvalid  <= w_gnt0 & ~m0_we;
         r_m1_rvalid  <= w_gnt1 & ~m1_we;
      end
   end

   // Gating with rstb drops a read whose data would land during reset.
   assign w_m0_rvalid = r_m0_rvalid & rstb;
   assign w_m1_rvalid = r_m1_rvalid & rstb;

   assign m0_gnt      = w_gnt0;
   assign m1_gnt      = w_gnt1;
   assign m0_rvalid   = w_m0_rvalid;
   assign m1_rvalid   = w_m1_rvalid;
   assign m0_rdata    = w_m0_rvalid ? mem_rd_data : '0;
   assign m1_rdata    = w_m1_rvalid ? mem_rd_data : '0;

   // Master 0 drives the memory bus whenever master 1 is not granted.
   assign mem_addr    = w_gnt1 ? m1_addr  : m0_addr;
   assign mem_wr_data = w_gnt1 ? m1_wdata : m0_wdata;
   assign mem_wr_ena  = (w_gnt0 & m0_we) | (w_gnt1 & m1_we);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a behavioural
//               arbitration/memory model, directed scenarios and a random
//               phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
   localparam int MAX_HOLD = 4;

   logic        clk;
   logic        rstb;
   logic        m0_req, m0_we, m0_lock;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_gnt, m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we, m1_lock;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_rvalid;
   logic [31:0] m1_rdata;
   logic [31:0] mem_addr, mem_wr_data;
   logic        mem_wr_ena;
   logic [31:0] mem_rd_data;

   mem_port_arbiter #(.MAX_HOLD(MAX_HOLD), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rstb(rstb),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
      .mem_rd_data(mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory attached to the DUT: synchronous read, one-cycle latency.
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (mem_wr_ena) mem[mem_addr[9:2]] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr[9:2]];
   end

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   int          prev_owner;   // -1: nobody granted last cycle
   int          last_owner;
   int          hold;
   bit          lock_flag;
   bit          rv0, rv1;
   logic [31:0] rd0, rd1;
   logic [31:0] ref_mem [256];
   int          cur_g;        // model grant for the current cycle, -1 none
   logic        obs_g0, obs_g1, obs_rv0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic model_comb();
      if (!rstb) cur_g = -1;
      else if (m0_req && m1_req) begin
         if (prev_owner >= 0 && lock_flag && hold < MAX_HOLD) cur_g = prev_owner;
         else cur_g = 1 - last_owner;
      end
      else if (m0_req) cur_g = 0;
      else if (m1_req) cur_g = 1;
      else cur_g = -1;
   endtask

   task automatic model_seq();
      bit other;
      if (!rstb) begin
         prev_owner = -1; last_owner = 1; hold = 0; lock_flag = 0;
         rv0 = 0; rv1 = 0;
      end else begin
         rv0 = (cur_g == 0) && !m0_we;
         rv1 = (cur_g == 1) && !m1_we;
         rd0 = ref_mem[m0_addr[9:2]];
         rd1 = ref_mem[m1_addr[9:2]];
         if (cur_g == 0 && m0_we) ref_mem[m0_addr[9:2]] = m0_wdata;
         if (cur_g == 1 && m1_we) ref_mem[m1_addr[9:2]] = m1_wdata;
         other = (cur_g == 0) ? m1_req : m0_req;
         if (cur_g >= 0 && cur_g == prev_owner && other) hold = (hold >= 15) ? 15 : hold + 1;
         else hold = 0;
         lock_flag = (cur_g == 0) ? m0_lock : (cur_g == 1) ? m1_lock : 1'b0;
         if (cur_g >= 0) last_owner = cur_g;
         prev_owner = cur_g;
      end
   endtask

   // One clock cycle: check outputs mid-cycle, then advance the model.
   task automatic step();
      logic [31:0] e_addr, e_wdat;
      logic        e_we;
      #2;
      model_comb();
      e_addr = (cur_g == 1) ? m1_addr  : m0_addr;
      e_wdat = (cur_g == 1) ? m1_wdata : m0_wdata;
      e_we   = (cur_g == 0) ? m0_we : (cur_g == 1) ? m1_we : 1'b0;
      chk("m0_gnt",      32'(m0_gnt),     32'(cur_g == 0));
      chk("m1_gnt",      32'(m1_gnt),     32'(cur_g == 1));
      chk("gnt_onehot",  32'(m0_gnt & m1_gnt), 32'd0);
      chk("mem_addr",    mem_addr,        e_addr);
      chk("mem_wr_data", mem_wr_data,     e_wdat);
      chk("mem_wr_ena",  32'(mem_wr_ena), 32'(e_we));
      chk("m0_rvalid",   32'(m0_rvalid),  32'(rstb && rv0));
      chk("m1_rvalid",   32'(m1_rvalid),  32'(rstb && rv1));
      chk("m0_rdata",    m0_rdata,        (rstb && rv0) ? rd0 : 32'd0);
      chk("m1_rdata",    m1_rdata,        (rstb && rv1) ? rd1 : 32'd0);
      obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid;
      @(posedge clk);
      model_seq();
      #1;
   endtask

   task automatic rand_master0();
      m0_req = ($urandom_range(0, 3) != 0); m0_we = $urandom_range(0, 1) != 0;
      m0_lock = $urandom_range(0, 1) != 0; m0_addr = $urandom; m0_wdata = $urandom;
   endtask

   task automatic rand_master1();
      m1_req = ($urandom_range(0, 3) != 0); m1_we = $urandom_range(0, 1) != 0;
      m1_lock = $urandom_range(0, 1) != 0; m1_addr = $urandom; m1_wdata = $urandom;
   endtask

   initial begin
      int run;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
         ref_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
      end
      prev_owner = -1; last_owner = 1; hold = 0; lock_flag = 0;
      rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0; cur_g = -1;
      rstb = 0;
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;

      // Reset
      repeat (3) step();
      rstb = 1;

      // m0 reads 0x00400000 alone for 3 cycles
      m0_req = 1; m0_addr = 32'h0040_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("solo_m0_gnt", 32'(obs_g0), 32'd1);
      end
      m0_req = 0;
      step();
      chk("solo_m0_last_rvalid", 32'(obs_rv0), 32'd1);

      // Reset pulse, then continuous tie without lock: alternates, m0 first
      rstb = 0; step(); rstb = 1;
      m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h80;
      step();
      chk("first_tie_m0", 32'(obs_g0), 32'd1);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("rr_alternate_m1", 32'(obs_g1), 32'(i % 2 == 0));
      end

      // m1 locked write burst against a requesting m0
      m0_req = 0; m1_req = 0; step();
      m0_req = 1; m0_we = 0; m0_addr = 32'h100;
      m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h10; m1_wdata = 32'hDEADBEEF;
      run = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (obs_g1) run++;
         else if (run > 0) break;
      end
      chk("lock_run_len", 32'(run), 32'(MAX_HOLD + 1));
      chk("lock_then_m0", 32'(obs_g0), 32'd1);

      // m1 locks alone for 20 cycles, then m0 competes
      m0_req = 0; m1_addr = 32'h14; m1_wdata = 32'h1234_5678;
      run = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_g1) run++;
      end
      chk("solo_lock_grants", 32'(run), 32'd20);
      m0_req = 1;
      run = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (obs_g1) run++;
         else break;
      end
      chk("lock_after_solo", 32'(run), 32'(MAX_HOLD));
      chk("m0_after_solo", 32'(obs_g0), 32'd1);

      // Alternating reads m0@0x100 / m1@0x200
      m1_lock = 0; m1_we = 0; m1_addr = 32'h200; m0_addr = 32'h100;
      repeat (6) step();

      // Reset in the cycle after an m0 read grant
      m1_req = 0;
      step();
      chk("pre_rst_m0_gnt", 32'(obs_g0), 32'd1);
      rstb = 0; m0_req = 0;
      step();
      chk("rst_drops_rvalid", 32'(obs_rv0), 32'd0);
      rstb = 1; m0_req = 1; m1_req = 1;
      step();
      chk("post_rst_tie_m0", 32'(obs_g0), 32'd1);

      // Random phase; an ungranted requester keeps its command stable
      for (int i = 0; i < 400; i++) begin
         if (!m0_req || cur_g == 0) rand_master0();
         if (!m1_req || cur_g == 1) rand_master1();
         rstb = ($urandom_range(0, 49) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
